// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo-MODULUS up/down counter with
// parallel load, synchronous clear, terminal-count and wrap flags, and an
// optional one-shot mode that freezes at the terminal value.
module mod_updown_counter #(
    parameter int unsigned     WIDTH   = 32'd4,
    parameter longint unsigned MODULUS = 64'd16,
    parameter bit              ONESHOT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             done_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Terminal value and unit step, both one bit wider than the counter so
    // MODULUS = 2**WIDTH is handled without overflow in the compares.
    localparam logic [WIDTH:0]   MAX_C    = (WIDTH + 1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0]   ONE_C    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_q,    q_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    state_e           state_q, state_d;

    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic [WIDTH:0]   load_ext_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             tc_s;

    assign q_ext_s    = {1'b0, q_q};
    assign inc_s      = q_ext_s + ONE_C;
    assign dec_s      = q_ext_s - ONE_C;
    assign load_ext_s = {1'b0, load_val_i};

    // q is always within 0..MODULUS-1, so an increment beyond MAX_C means q
    // sits on the top value, and a borrow out of the decrement means q is 0.
    assign at_max_s  = (inc_s > MAX_C);
    assign at_zero_s = dec_s[WIDTH];
    assign tc_s      = en_i & ((up_dn_i & at_max_s) | (~up_dn_i & at_zero_s));

    // Next-state and flag logic; priority is clear, then load, then counting.
    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        state_d = state_q;
        if (clr_i) begin
            q_d     = ZERO_W_C;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (load_i) begin
            if (load_ext_s > MAX_C) begin
                q_d = MAX_C[WIDTH-1:0];
            end else begin
                q_d = load_val_i;
            end
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
            done_d = 1'b1;
        end else if (ONESHOT && tc_s) begin
            // One-shot: freeze on the terminal value instead of wrapping.
            done_d  = 1'b1;
            state_d = ST_DONE;
        end else if (en_i) begin
            if (up_dn_i) begin
                if (at_max_s) begin
                    q_d    = ZERO_W_C;
                    wrap_d = 1'b1;
                end else begin
                    q_d = inc_s[WIDTH-1:0];
                end
            end else begin
                if (at_zero_s) begin
                    q_d    = MAX_C[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    q_d = dec_s[WIDTH-1:0];
                end
            end
        end else begin
            q_d = q_q;
        end
    end

    // State register with asynchronous active-high reset into RUN at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q     <= ZERO_W_C;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;
    assign done_o = done_q;
    assign tc_o   = tc_s;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: four instances with different
// parameters share one set of inputs; each task checks the instance it targets.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;

    logic [3:0] q16, q10, q6;
    logic [0:0] q2;
    logic       tc16, tc10, tc6, tc2;
    logic       wrap16, wrap10, wrap6, wrap2;
    logic       done16, done10, done6, done2;

    int checks   = 0;
    int failures = 0;

    mod_updown_counter #(.WIDTH(32'd4), .MODULUS(64'd16), .ONESHOT(1'b0)) dut16 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .en_i(en), .up_dn_i(up_dn), .q_o(q16), .tc_o(tc16), .wrap_o(wrap16), .done_o(done16));

    mod_updown_counter #(.WIDTH(32'd4), .MODULUS(64'd10), .ONESHOT(1'b0)) dut10 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .en_i(en), .up_dn_i(up_dn), .q_o(q10), .tc_o(tc10), .wrap_o(wrap10), .done_o(done10));

    mod_updown_counter #(.WIDTH(32'd4), .MODULUS(64'd6), .ONESHOT(1'b1)) dut6 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .en_i(en), .up_dn_i(up_dn), .q_o(q6), .tc_o(tc6), .wrap_o(wrap6), .done_o(done6));

    mod_updown_counter #(.WIDTH(32'd1), .MODULUS(64'd2), .ONESHOT(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val[0:0]),
        .en_i(en), .up_dn_i(up_dn), .q_o(q2), .tc_o(tc2), .wrap_o(wrap2), .done_o(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up_dn = 1'b1;
        tick();
        tick();
        checks++; if (q16 !== 4'd0) begin failures++; $display("FAIL reset_q16: got %0d, expected 0", q16); end
        checks++; if (q10 !== 4'd0) begin failures++; $display("FAIL reset_q10: got %0d, expected 0", q10); end
        checks++; if (q6 !== 4'd0) begin failures++; $display("FAIL reset_q6: got %0d, expected 0", q6); end
        checks++; if (q2 !== 1'b0) begin failures++; $display("FAIL reset_q2: got %0d, expected 0", q2); end
        checks++; if (wrap16 !== 1'b0) begin failures++; $display("FAIL reset_wrap16: got %0d, expected 0", wrap16); end
        checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL reset_done6: got %0d, expected 0", done6); end
        checks++; if (tc16 !== 1'b0) begin failures++; $display("FAIL reset_tc16: got %0d, expected 0", tc16); end
        rst = 1'b0;
    endtask

    task automatic test_count_up16;
        do_clear();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++; if (q16 !== 4'(i % 16)) begin failures++; $display("FAIL up16_q step %0d: got %0d, expected %0d", i, q16, i % 16); end
            checks++; if (wrap16 !== (i == 16)) begin failures++; $display("FAIL up16_wrap step %0d: got %0d, expected %0d", i, wrap16, (i == 16)); end
            checks++; if (tc16 !== (i == 15)) begin failures++; $display("FAIL up16_tc step %0d: got %0d, expected %0d", i, tc16, (i == 15)); end
            checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL up16_done step %0d: got %0d, expected 0", i, done16); end
        end
        // Asynchronous reset between edges, then held across an enabled edge.
        #2 rst = 1'b1;
        #1;
        checks++; if (q16 !== 4'd0) begin failures++; $display("FAIL async_rst_q16: got %0d, expected 0", q16); end
        tick();
        checks++; if (q16 !== 4'd0) begin failures++; $display("FAIL rst_hold_q16: got %0d, expected 0", q16); end
        rst = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_up_down10;
        do_clear();
        load_val = 4'd8; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (q10 !== 4'd8) begin failures++; $display("FAIL m10_load8: got %0d, expected 8", q10); end
        en = 1'b1; up_dn = 1'b1;
        tick();
        checks++; if (q10 !== 4'd9) begin failures++; $display("FAIL m10_up9: got %0d, expected 9", q10); end
        checks++; if (tc10 !== 1'b1) begin failures++; $display("FAIL m10_tc_up: got %0d, expected 1", tc10); end
        tick();
        checks++; if (q10 !== 4'd0) begin failures++; $display("FAIL m10_upwrap_q: got %0d, expected 0", q10); end
        checks++; if (wrap10 !== 1'b1) begin failures++; $display("FAIL m10_upwrap_flag: got %0d, expected 1", wrap10); end
        load_val = 4'd3; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (q10 !== 4'd3) begin failures++; $display("FAIL m10_load3: got %0d, expected 3", q10); end
        checks++; if (wrap10 !== 1'b0) begin failures++; $display("FAIL m10_load_wrap: got %0d, expected 0", wrap10); end
        up_dn = 1'b0;
        begin
            int exp_q[4] = '{2, 1, 0, 9};
            int exp_w[4] = '{0, 0, 0, 1};
            int exp_t[4] = '{0, 0, 1, 0};
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++; if (q10 !== 4'(exp_q[i])) begin failures++; $display("FAIL m10_down_q step %0d: got %0d, expected %0d", i, q10, exp_q[i]); end
                checks++; if (wrap10 !== 1'(exp_w[i])) begin failures++; $display("FAIL m10_down_wrap step %0d: got %0d, expected %0d", i, wrap10, exp_w[i]); end
                checks++; if (tc10 !== 1'(exp_t[i])) begin failures++; $display("FAIL m10_down_tc step %0d: got %0d, expected %0d", i, tc10, exp_t[i]); end
            end
        end
        en = 1'b0;
        tick();
        checks++; if (q10 !== 4'd9) begin failures++; $display("FAIL m10_hold: got %0d, expected 9", q10); end
        checks++; if (wrap10 !== 1'b0) begin failures++; $display("FAIL m10_hold_wrap: got %0d, expected 0", wrap10); end
    endtask

    task automatic test_load_clamp;
        en = 1'b0;
        load_val = 4'd12; load = 1'b1;
        tick();
        checks++; if (q10 !== 4'd9) begin failures++; $display("FAIL clamp_q10: got %0d, expected 9", q10); end
        checks++; if (q16 !== 4'd12) begin failures++; $display("FAIL noclamp_q16: got %0d, expected 12", q16); end
        load_val = 4'd5; clr = 1'b1;
        tick();
        checks++; if (q10 !== 4'd0) begin failures++; $display("FAIL clr_over_load_q10: got %0d, expected 0", q10); end
        checks++; if (q16 !== 4'd0) begin failures++; $display("FAIL clr_over_load_q16: got %0d, expected 0", q16); end
        clr = 1'b0; load = 1'b0;
    endtask

    task automatic test_oneshot;
        do_clear();
        checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL os_clr_done: got %0d, expected 0", done6); end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (q6 !== 4'(i)) begin failures++; $display("FAIL os_q step %0d: got %0d, expected %0d", i, q6, i); end
            checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL os_done step %0d: got %0d, expected 0", i, done6); end
            checks++; if (wrap6 !== 1'b0) begin failures++; $display("FAIL os_wrap step %0d: got %0d, expected 0", i, wrap6); end
        end
        checks++; if (tc6 !== 1'b1) begin failures++; $display("FAIL os_tc_at5: got %0d, expected 1", tc6); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) up_dn = 1'b0;
            tick();
            checks++; if (q6 !== 4'd5) begin failures++; $display("FAIL os_stop_q cycle %0d: got %0d, expected 5", i, q6); end
            checks++; if (done6 !== 1'b1) begin failures++; $display("FAIL os_stop_done cycle %0d: got %0d, expected 1", i, done6); end
            checks++; if (wrap6 !== 1'b0) begin failures++; $display("FAIL os_stop_wrap cycle %0d: got %0d, expected 0", i, wrap6); end
        end
        up_dn = 1'b1;
        load_val = 4'd2; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (q6 !== 4'd2) begin failures++; $display("FAIL os_reload_q: got %0d, expected 2", q6); end
        checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL os_reload_done: got %0d, expected 0", done6); end
        for (int i = 3; i <= 5; i++) begin
            tick();
            checks++; if (q6 !== 4'(i)) begin failures++; $display("FAIL os_resume_q %0d: got %0d, expected %0d", i, q6, i); end
        end
        tick();
        checks++; if (q6 !== 4'd5) begin failures++; $display("FAIL os_second_stop_q: got %0d, expected 5", q6); end
        checks++; if (done6 !== 1'b1) begin failures++; $display("FAIL os_second_done: got %0d, expected 1", done6); end
        en = 1'b0;
    endtask

    task automatic test_direction_toggle;
        do_clear();
        load_val = 4'd5; load = 1'b1;
        tick();
        load = 1'b0;
        begin
            int en_v[7]  = '{1, 0, 1, 0, 1, 0, 1};
            int up_v[7]  = '{1, 1, 1, 1, 0, 0, 0};
            int exp_q[7] = '{6, 6, 7, 7, 6, 6, 5};
            for (int i = 0; i < 7; i++) begin
                en = 1'(en_v[i]);
                up_dn = 1'(up_v[i]);
                tick();
                checks++; if (q16 !== 4'(exp_q[i])) begin failures++; $display("FAIL dir_q step %0d: got %0d, expected %0d", i, q16, exp_q[i]); end
            end
        end
        checks++; if (done6 !== 1'b1) begin failures++; $display("FAIL dir_done6_before_rst: got %0d, expected 1", done6); end
        #2 rst = 1'b1;
        #1;
        checks++; if (q16 !== 4'd0) begin failures++; $display("FAIL dir_rst_q16: got %0d, expected 0", q16); end
        checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL dir_rst_done6: got %0d, expected 0", done6); end
        checks++; if (q6 !== 4'd0) begin failures++; $display("FAIL dir_rst_q6: got %0d, expected 0", q6); end
        #1 rst = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_clear();
        en = 1'b1; up_dn = 1'b1;
        begin
            int exp_q[4] = '{1, 0, 1, 0};
            int exp_w[4] = '{0, 1, 0, 1};
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++; if (q2 !== 1'(exp_q[i])) begin failures++; $display("FAIL m2_q step %0d: got %0d, expected %0d", i, q2, exp_q[i]); end
                checks++; if (wrap2 !== 1'(exp_w[i])) begin failures++; $display("FAIL m2_wrap step %0d: got %0d, expected %0d", i, wrap2, exp_w[i]); end
            end
        end
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL m2_done: got %0d, expected 0", done2); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up16();
        test_up_down10();
        test_load_clamp();
        test_oneshot();
        test_direction_toggle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
